mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- Initiator side of the single-port-style data RAM (combinational read port, synchronous write port, 64-bit doubleword lines).
- Accepts one load/store request at a time from the MEM stage through a valid/ready handshake.
- Converts each request into RAM doubleword accesses: sub-word stores become read-modify-write; loads get lane extraction and sign/zero extension.
- Returns a response (load data or error) through a valid/ready handshake.

Parameters:
- ADDR_W, 64, CPU byte-address width.
- RAM_ADDR_W, 16, RAM doubleword-index width (RAM depth = 2^RAM_ADDR_W lines).
- BASE_ADDR, 64'h8000_0000, byte address mapped to RAM line 0.

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  synchronous, active-high reset
- req_valid_i  input  1  request present
- req_ready_o  output  1  unit can accept a request
- req_addr_i  input  ADDR_W  byte address
- req_wdata_i  input  64  store data, right-aligned
- req_size_i  input  2  0=byte, 1=half, 2=word, 3=dword
- req_store_i  input  1  1=store, 0=load
- req_unsigned_i  input  1  zero-extend load result
- resp_valid_o  output  1  response present
- resp_ready_i  input  1  consumer accepts response
- resp_rdata_o  output  64  extended load data; 0 for stores and errors
- resp_err_o  output  1  misaligned or out-of-range access
- ram_raddr_o  output  RAM_ADDR_W  RAM read line index
- ram_rdata_i  input  64  RAM read data, combinational from ram_raddr_o
- ram_waddr_o  output  RAM_ADDR_W  RAM write line index
- ram_wdata_o  output  64  merged line to write
- ram_we_o  output  1  RAM write strobe, one cycle

Behaviour:
- Clock and reset: one clock domain, clk; reset is synchronous and active-high on rst.
- Reset:
  - The state machine goes to IDLE and all internal registers clear.
  - While rst is high, every output is forced to 0: req_ready_o=0, resp_valid_o=0, resp_err_o=0, ram_we_o=0, all buses 0.
- States: IDLE, READ, WRITE, RESP.
- IDLE:
  - req_ready_o=1.
  - On req_valid_i, latch addr, wdata, size, store and unsigned.
  - offset = addr - BASE_ADDR, modulo 2^ADDR_W. line = offset[RAM_ADDR_W+2:3]. lane = offset[2:0].
  - Misaligned when (size=1 and lane[0]), (size=2 and lane[1:0]!=0), or (size=3 and lane!=0).
  - Out-of-range when offset >= 8*2^RAM_ADDR_W; this includes addr < BASE_ADDR, via wrap.
  - If misaligned or out-of-range: set err=1 and go to RESP. No RAM access occurs.
  - Otherwise go to READ.
- READ (1 cycle):
  - ram_raddr_o=line.
  - Load: select bytes [lane*8 +: 8<<size], extend them, register the result, go to RESP.
  - Store: merge the low (8<<size) bits of wdata into the read line at lane, register the merged line, go to WRITE.
  - The read also occurs for size=3 stores; the result is fully overwritten.
- WRITE (1 cycle): ram_waddr_o=line, ram_wdata_o=merged line, ram_we_o=1, then go to RESP.
- RESP:
  - resp_valid_o=1 and req_ready_o=0.
  - resp_rdata_o and resp_err_o hold stable until resp_ready_i is high at a clock edge, then go to IDLE.
  - resp_ready_i may already be high on the first RESP cycle.
- Latency, counted from the request-accept edge as cycle 0:
  - Error response valid in cycle 1.
  - Load response valid in cycle 2.
  - Store: RAM write in cycle 2, response valid in cycle 3.
  - Throughput: at most one request per (latency + 1) cycles; no back-to-back overlap.
- Output timing:
  - ram_we_o is high only in WRITE and never for erroring requests.
  - ram_raddr_o/ram_waddr_o drive 0 outside READ/WRITE.
- Reset mid-operation: rst asserted in WRITE suppresses ram_we_o in that cycle. The pending store is lost, and no response is produced.
- Extension: signed loads replicate the top selected bit; unsigned loads and size=3 pass the value unchanged.

Decomposition:
- Shared defines file:
  - size encodings (SIZE_B/H/W/D)
  - state encodings
  - RAM_ADDR_BUS, RAM_DATA_BUS, RAM_DATA_ZERO
- Sub-module lane_merge_extract:
  - purely combinational
  - inputs: line, lane, size, wdata, unsigned
  - outputs: merged line and extended load value
  - shared so that a later store buffer can reuse it

Test Plan:
- Reset: hold rst 3 cycles mid-store (in WRITE) -> ram_we_o stays 0, resp_valid_o never rises, req_ready_o=1 the cycle after rst drops.
- Signed byte load: RAM line 0 = 64'h0000_0000_0000_8000, load size=0 addr=0x8000_0001, unsigned=0 -> cycle 2 resp_rdata_o=64'hFFFF_FFFF_FFFF_FF80, err=0. Same with unsigned=1 -> 64'h80.
- Half store RMW: line 2 = 64'h1122_3344_5566_7788, store size=1 addr=0x8000_0014 wdata=0xABCD -> cycle 2 ram_we_o=1, waddr=2, wdata=64'h1122_ABCD_5566_7788; response cycle 3.
- Misaligned word load addr=0x8000_0002 -> cycle 1 resp_err_o=1, rdata=0, no ram_we_o.
- Out-of-range dword store addr=0x7FFF_FFF8 -> resp_err_o=1, RAM unchanged.
- Backpressure: hold resp_ready_i=0 for 5 cycles on a dword load of 64'hDEAD_BEEF_0123_4567 -> resp outputs stable, req_ready_o=0 throughout; a new request is accepted only after the handshake.

Source files
------------

// File: rtl/mem_access_unit_pkg.sv
// Shared encodings and bus sizes for the data-RAM access unit and its helpers.
package mem_access_unit_pkg;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;
  localparam logic [1:0] SIZE_D = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  localparam int RAM_ADDR_BUS = 16;
  localparam int RAM_DATA_BUS = 64;
  localparam logic [RAM_DATA_BUS-1:0] RAM_DATA_ZERO = '0;

  function automatic logic [3:0] size_bytes(input logic [1:0] size);
    return 4'd1 << size;
  endfunction

endpackage

// File: rtl/lane_merge_extract.sv
// Combinational lane logic: merges store data into a doubleword line and
// extracts/extends a load value from it.
module lane_merge_extract
  import mem_access_unit_pkg::*;
(
  input  logic [RAM_DATA_BUS-1:0] line,
  input  logic [2:0]              lane,
  input  logic [1:0]              size,
  input  logic [RAM_DATA_BUS-1:0] wdata,
  input  logic                    zext,
  output logic [RAM_DATA_BUS-1:0] merged,
  output logic [RAM_DATA_BUS-1:0] load_val
);

  logic [RAM_DATA_BUS-1:0] line_shift;
  logic [RAM_DATA_BUS-1:0] wdata_shift;
  logic [4:0]              lane_end;

  assign line_shift  = line >> {lane, 3'b000};
  assign wdata_shift = wdata << {lane, 3'b000};
  assign lane_end    = {2'b00, lane} + {1'b0, size_bytes(size)};

  // A byte takes store data when it lies inside [lane, lane + access size).
  generate
    for (genvar gi = 0; gi < RAM_DATA_BUS / 8; gi++) begin : g_byte
      logic byte_en;
      assign byte_en = (5'(gi) >= {2'b00, lane}) && (5'(gi) < lane_end);
      assign merged[gi*8 +: 8] = byte_en ? wdata_shift[gi*8 +: 8] : line[gi*8 +: 8];
    end
  endgenerate

  always_comb begin
    load_val = RAM_DATA_ZERO;
    case (size)
      SIZE_B: load_val = zext ? {56'b0, line_shift[7:0]}
                              : {{56{line_shift[7]}}, line_shift[7:0]};
      SIZE_H: load_val = zext ? {48'b0, line_shift[15:0]}
                              : {{48{line_shift[15]}}, line_shift[15:0]};
      SIZE_W: load_val = zext ? {32'b0, line_shift[31:0]}
                              : {{32{line_shift[31]}}, line_shift[31:0]};
      SIZE_D: load_val = line_shift;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store initiator for a doubleword data RAM: one request at a time,
// read-modify-write for sub-word stores, extended load data on the response.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int              ADDR_W     = 64,
  parameter int              RAM_ADDR_W = RAM_ADDR_BUS,
  parameter logic [ADDR_W-1:0] BASE_ADDR  = 64'h8000_0000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid_i,
  output logic                    req_ready_o,
  input  logic [ADDR_W-1:0]       req_addr_i,
  input  logic [RAM_DATA_BUS-1:0] req_wdata_i,
  input  logic [1:0]              req_size_i,
  input  logic                    req_store_i,
  input  logic                    req_unsigned_i,
  output logic                    resp_valid_o,
  input  logic                    resp_ready_i,
  output logic [RAM_DATA_BUS-1:0] resp_rdata_o,
  output logic                    resp_err_o,
  output logic [RAM_ADDR_W-1:0]   ram_raddr_o,
  input  logic [RAM_DATA_BUS-1:0] ram_rdata_i,
  output logic [RAM_ADDR_W-1:0]   ram_waddr_o,
  output logic [RAM_DATA_BUS-1:0] ram_wdata_o,
  output logic                    ram_we_o
);

  state_e                  state_reg;
  logic [RAM_ADDR_W-1:0]   line_reg;
  logic [2:0]              lane_reg;
  logic [1:0]              size_reg;
  logic                    store_reg;
  logic                    zext_reg;
  logic                    err_reg;
  logic [RAM_DATA_BUS-1:0] wdata_reg;
  logic [RAM_DATA_BUS-1:0] data_reg;

  logic [ADDR_W-1:0]       offset_next;
  logic                    oor_next;
  logic                    misalign_next;
  logic [RAM_DATA_BUS-1:0] merged;
  logic [RAM_DATA_BUS-1:0] load_val;

  // Addresses below BASE_ADDR wrap to huge offsets and fail the range check.
  assign offset_next = req_addr_i - BASE_ADDR;
  assign oor_next    = |offset_next[ADDR_W-1:RAM_ADDR_W+3];

  always_comb begin
    misalign_next = 1'b0;
    case (req_size_i)
      SIZE_H:  misalign_next = offset_next[0];
      SIZE_W:  misalign_next = |offset_next[1:0];
      SIZE_D:  misalign_next = |offset_next[2:0];
      default: misalign_next = 1'b0;
    endcase
  end

  lane_merge_extract u_lane (
    .line     (ram_rdata_i),
    .lane     (lane_reg),
    .size     (size_reg),
    .wdata    (wdata_reg),
    .zext     (zext_reg),
    .merged   (merged),
    .load_val (load_val)
  );

  // data_reg holds the merged line in WRITE and the response data in RESP.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      line_reg  <= '0;
      lane_reg  <= '0;
      size_reg  <= '0;
      store_reg <= 1'b0;
      zext_reg  <= 1'b0;
      err_reg   <= 1'b0;
      wdata_reg <= RAM_DATA_ZERO;
      data_reg  <= RAM_DATA_ZERO;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (req_valid_i) begin
            line_reg  <= offset_next[RAM_ADDR_W+2:3];
            lane_reg  <= offset_next[2:0];
            size_reg  <= req_size_i;
            store_reg <= req_store_i;
            zext_reg  <= req_unsigned_i;
            wdata_reg <= req_wdata_i;
            data_reg  <= RAM_DATA_ZERO;
            err_reg   <= oor_next | misalign_next;
            state_reg <= (oor_next | misalign_next) ? ST_RESP : ST_READ;
          end
        end
        ST_READ: begin
          if (store_reg) begin
            data_reg  <= merged;
            state_reg <= ST_WRITE;
          end else begin
            data_reg  <= load_val;
            state_reg <= ST_RESP;
          end
        end
        ST_WRITE: begin
          data_reg  <= RAM_DATA_ZERO;
          state_reg <= ST_RESP;
        end
        ST_RESP: begin
          if (resp_ready_i) begin
            err_reg   <= 1'b0;
            data_reg  <= RAM_DATA_ZERO;
            state_reg <= ST_IDLE;
          end
        end
      endcase
    end
  end

  // Outputs are gated by rst so an in-flight write is squashed immediately.
  assign req_ready_o  = !rst && (state_reg == ST_IDLE);
  assign resp_valid_o = !rst && (state_reg == ST_RESP);
  assign resp_rdata_o = resp_valid_o ? data_reg : RAM_DATA_ZERO;
  assign resp_err_o   = resp_valid_o && err_reg;
  assign ram_raddr_o  = (!rst && state_reg == ST_READ) ? line_reg : '0;
  assign ram_we_o     = !rst && (state_reg == ST_WRITE);
  assign ram_waddr_o  = ram_we_o ? line_reg : '0;
  assign ram_wdata_o  = ram_we_o ? data_reg : RAM_DATA_ZERO;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed plus randomized bench for mem_access_unit with a byte-level
// reference model of the RAM and the access rules.
module tb_mem_access_unit;

  localparam logic [63:0] BASE = 64'h8000_0000;
  localparam logic [63:0] SPAN = 64'h8_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [63:0] req_addr = '0;
  logic [63:0] req_wdata = '0;
  logic [1:0]  req_size = '0;
  logic        req_store = 1'b0;
  logic        req_unsigned = 1'b0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [63:0] resp_rdata;
  logic        resp_err;
  logic [15:0] ram_raddr;
  logic [63:0] ram_rdata;
  logic [15:0] ram_waddr;
  logic [63:0] ram_wdata;
  logic        ram_we;

  logic        tb_we = 1'b0;
  logic [15:0] tb_waddr = '0;
  logic [63:0] tb_wdata = '0;

  logic [63:0] mem  [0:65535];
  logic [63:0] refm [0:65535];

  int n_vec = 0;
  int n_err = 0;
  logic [63:0] last_rdata;
  logic        last_err;

  always #5 clk = ~clk;

  mem_access_unit dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid_i    (req_valid),
    .req_ready_o    (req_ready),
    .req_addr_i     (req_addr),
    .req_wdata_i    (req_wdata),
    .req_size_i     (req_size),
    .req_store_i    (req_store),
    .req_unsigned_i (req_unsigned),
    .resp_valid_o   (resp_valid),
    .resp_ready_i   (resp_ready),
    .resp_rdata_o   (resp_rdata),
    .resp_err_o     (resp_err),
    .ram_raddr_o    (ram_raddr),
    .ram_rdata_i    (ram_rdata),
    .ram_waddr_o    (ram_waddr),
    .ram_wdata_o    (ram_wdata),
    .ram_we_o       (ram_we)
  );

  assign ram_rdata = mem[ram_raddr];

  always @(posedge clk) begin
    if (ram_we) mem[ram_waddr] <= ram_wdata;
    else if (tb_we) mem[tb_waddr] <= tb_wdata;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic preload(input int line, input logic [63:0] data);
    @(negedge clk);
    tb_we = 1'b1; tb_waddr = 16'(line); tb_wdata = data;
    refm[line] = data;
    @(posedge clk); #1;
    tb_we = 1'b0;
  endtask

  function automatic logic [7:0] ref_byte(input logic [63:0] o);
    logic [63:0] l;
    l = refm[o[18:3]];
    return l[o[2:0]*8 +: 8];
  endfunction

  // One full transaction; expectations come from the address/size rules alone.
  task automatic do_txn(input logic [63:0] addr, input logic [63:0] wdata,
                        input logic [1:0] size, input logic st, input logic un,
                        input int hold);
    logic [63:0] off, e_rdata, e_line, we_addr, we_data;
    int n, e_lat, cyc, we_cyc, e_we_cyc;
    logic e_err, got;
    off   = addr - BASE;
    n     = 1 << size;
    e_err = (off >= SPAN) || ((off % 64'(n)) != 0);
    e_lat = e_err ? 1 : (st ? 3 : 2);
    e_we_cyc = (!e_err && st) ? 2 : 0;
    e_rdata = '0;
    e_line  = '0;
    if (!e_err && !st) begin
      for (int i = 0; i < n; i++) e_rdata[8*i +: 8] = ref_byte(off + 64'(i));
      if (!un && n < 8 && e_rdata[8*n-1])
        for (int b = 8*n; b < 64; b++) e_rdata[b] = 1'b1;
    end
    if (!e_err && st) begin
      e_line = refm[off[18:3]];
      for (int i = 0; i < n; i++) e_line[(int'(off[2:0]) + i)*8 +: 8] = wdata[8*i +: 8];
    end

    @(negedge clk);
    req_addr = addr; req_wdata = wdata; req_size = size;
    req_store = st; req_unsigned = un; req_valid = 1'b1;
    resp_ready = (hold == 0);
    chk("req_ready_idle", 64'(req_ready), 64'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;

    cyc = 1; we_cyc = 0; got = 1'b0; we_addr = '0; we_data = '0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (ram_we) begin
        we_cyc = cyc; we_addr = 64'(ram_waddr); we_data = ram_wdata;
      end
      if (resp_valid) begin
        got = 1'b1;
        break;
      end
      @(posedge clk); #1;
      cyc++;
    end
    chk("latency", got ? 64'(cyc) : 64'hFFFF, 64'(e_lat));
    chk("we_cycle", 64'(we_cyc), 64'(e_we_cyc));
    if (!e_err && st) begin
      chk("we_addr", we_addr, 64'(off[18:3]));
      chk("we_data", we_data, e_line);
      refm[off[18:3]] = e_line;
    end
    chk("rdata", resp_rdata, e_rdata);
    chk("err", 64'(resp_err), 64'(e_err));
    chk("req_ready_busy", 64'(req_ready), 64'd0);
    last_rdata = resp_rdata;
    last_err   = resp_err;

    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      @(negedge clk);
      chk("hold_valid", 64'(resp_valid), 64'd1);
      chk("hold_rdata", resp_rdata, e_rdata);
      chk("hold_err", 64'(resp_err), 64'(e_err));
      chk("hold_ready", 64'(req_ready), 64'd0);
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    @(negedge clk);
    chk("post_valid", 64'(resp_valid), 64'd0);
    chk("post_ready", 64'(req_ready), 64'd1);
    $display("txn addr=%h size=%0d store=%0d uns=%0d -> err=%0d rdata=%h lat=%0d",
             addr, size, st, un, resp_err, last_rdata, cyc);
  endtask

  initial begin
    logic [63:0] a, w, off;
    logic [1:0]  sz;
    int r, n;

    // Reset: outputs forced low while rst is high; RAM preloaded meanwhile.
    @(negedge clk);
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_resp_valid", 64'(resp_valid), 64'd0);
    chk("rst_we", 64'(ram_we), 64'd0);
    chk("rst_rdata", resp_rdata, 64'd0);
    chk("rst_raddr", 64'(ram_raddr), 64'd0);
    for (int i = 0; i < 32; i++) preload(i, {$urandom, $urandom});
    preload(0, 64'h0000_0000_0000_8000);
    preload(2, 64'h1122_3344_5566_7788);
    preload(5, 64'hDEAD_BEEF_0123_4567);
    @(posedge clk); #1;
    rst = 1'b0;

    // Directed cases.
    do_txn(64'h8000_0001, '0, 2'd0, 1'b0, 1'b0, 1);
    chk("sbyte_load", last_rdata, 64'hFFFF_FFFF_FFFF_FF80);
    do_txn(64'h8000_0001, '0, 2'd0, 1'b0, 1'b1, 0);
    chk("ubyte_load", last_rdata, 64'h0000_0000_0000_0080);
    do_txn(64'h8000_0014, 64'hABCD, 2'd1, 1'b1, 1'b0, 0);
    chk("half_rmw_mem", mem[2], 64'h1122_ABCD_5566_7788);
    do_txn(64'h8000_0002, '0, 2'd2, 1'b0, 1'b0, 0);
    chk("misalign_err", 64'(last_err), 64'd1);
    do_txn(64'h7FFF_FFF8, 64'h1234, 2'd3, 1'b1, 1'b0, 0);
    chk("oor_err", 64'(last_err), 64'd1);
    do_txn(64'h8000_0028, '0, 2'd3, 1'b0, 1'b0, 5);
    chk("dword_load", last_rdata, 64'hDEAD_BEEF_0123_4567);

    // Randomized traffic over the first 32 lines plus out-of-range probes.
    for (int t = 0; t < 40; t++) begin
      r  = int'($urandom_range(0, 9));
      sz = 2'($urandom_range(0, 3));
      n  = 1 << sz;
      off = 64'($urandom_range(0, 31)) * 8;
      if ($urandom_range(0, 3) == 0) off += 64'($urandom_range(0, 7));
      else off += 64'($urandom_range(0, (8 / n) - 1) * n);
      if (r == 0)      a = BASE - 64'($urandom_range(1, 64));
      else if (r == 1) a = BASE + SPAN + 64'($urandom_range(0, 100));
      else             a = BASE + off;
      w = {$urandom, $urandom};
      do_txn(a, w, sz, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             int'($urandom_range(0, 2)));
    end

    // Reset during WRITE squashes the store and its response.
    @(negedge clk);
    req_addr = BASE + 64'd80; req_wdata = 64'h0BAD_F00D_0BAD_F00D;
    req_size = 2'd3; req_store = 1'b1; req_unsigned = 1'b0; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("rstw_we_now", 64'(ram_we), 64'd0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("rstw_we", 64'(ram_we), 64'd0);
      chk("rstw_valid", 64'(resp_valid), 64'd0);
      @(posedge clk);
    end
    #1;
    rst = 1'b0;
    #1;
    chk("rstw_ready_after", 64'(req_ready), 64'd1);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("rstw_no_resp", 64'(resp_valid), 64'd0);
    end
    chk("rstw_mem_kept", mem[10], refm[10]);
    $display("reset-in-write: line10=%h", mem[10]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
